// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU / condition-code execution stage:
// bus widths, opcode encodings, FSM state encoding and CCR bit positions.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned DATAWIDTH_BUS           = 32;
  localparam int unsigned DATAWIDTH_ALU_SELECTION = 4;
  localparam int unsigned DATAWIDTH_SHAMT         = 5;
  localparam int unsigned CCR_W                   = 4;

  typedef logic [DATAWIDTH_ALU_SELECTION-1:0] alu_op_t;

  // Opcode encodings
  localparam alu_op_t ALU_ANDCC    = 4'd0;
  localparam alu_op_t ALU_ORCC     = 4'd1;
  localparam alu_op_t ALU_NORCC    = 4'd2;
  localparam alu_op_t ALU_ADDCC    = 4'd3;
  localparam alu_op_t ALU_SRL      = 4'd4;
  localparam alu_op_t ALU_AND      = 4'd5;
  localparam alu_op_t ALU_OR       = 4'd6;
  localparam alu_op_t ALU_NOR      = 4'd7;
  localparam alu_op_t ALU_ADD      = 4'd8;
  localparam alu_op_t ALU_LSHIFT2  = 4'd9;
  localparam alu_op_t ALU_LSHIFT10 = 4'd10;
  localparam alu_op_t ALU_SIMM13   = 4'd11;
  localparam alu_op_t ALU_SEXT13   = 4'd12;
  localparam alu_op_t ALU_INC      = 4'd13;
  localparam alu_op_t ALU_INCPC    = 4'd14;
  localparam alu_op_t ALU_RSHIFT5  = 4'd15;

  // CCR layout {n, z, v, c}
  localparam int unsigned CCR_N = 3;
  localparam int unsigned CCR_Z = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // The four flag-setting opcodes occupy the bottom of the opcode space
  function automatic logic is_cc_op(input alu_op_t op);
    return (op <= ALU_ADDCC);
  endfunction

endpackage

// File: rtl/sc_alu_combinational.sv
// -----------------------------------------------------------------------------
// sc_alu_combinational
// Pure function of (sel, a, b): single-cycle ALU result plus adder carry and
// signed overflow. SRL returns a unchanged; the serial shift lives upstream.
// Ports:
//   sel      in   opcode
//   a, b     in   operands (W bits)
//   result   out  combinational result (W bits)
//   carry    out  carry out of the adder MSB (a + b)
//   overflow out  signed overflow of a + b
// -----------------------------------------------------------------------------
module sc_alu_combinational
  import alu_pkg::*;
#(
  parameter int unsigned W = DATAWIDTH_BUS
) (
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] sel,
  input  logic [W-1:0]                       a,
  input  logic [W-1:0]                       b,
  output logic [W-1:0]                       result,
  output logic                               carry,
  output logic                               overflow
);

  localparam int unsigned IMM_W    = 13;
  // Sign bit of the 13-bit immediate, clamped for narrow buses
  localparam int unsigned SIGN_BIT = (W > IMM_W) ? IMM_W - 1 : W - 1;

  logic [W:0]   sum;
  logic [W-1:0] simm;
  logic [W-1:0] sext;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign carry    = sum[W];
  assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

  // Zero- and sign-extended views of a[12:0]
  always_comb begin
    simm = '0;
    sext = '0;
    for (int unsigned i = 0; i < W; i++) begin
      simm[i] = (i < IMM_W) ? a[i] : 1'b0;
      sext[i] = (i < IMM_W) ? a[i] : a[SIGN_BIT];
    end
  end

  // Opcode decode
  always_comb begin
    result = a;
    case (sel)
      ALU_ANDCC, ALU_AND: result = a & b;
      ALU_ORCC,  ALU_OR:  result = a | b;
      ALU_NORCC, ALU_NOR: result = ~(a | b);
      ALU_ADDCC, ALU_ADD: result = sum[W-1:0];
      ALU_SRL:            result = a;
      ALU_LSHIFT2:        result = a << 2;
      ALU_LSHIFT10:       result = a << 10;
      ALU_SIMM13:         result = simm;
      ALU_SEXT13:         result = sext;
      ALU_INC:            result = a + W'(1);
      ALU_INCPC:          result = a + W'(4);
      ALU_RSHIFT5:        result = a >> 5;
      default:            result = a;
    endcase
  end

endmodule

// File: rtl/alu_ccr_unit.sv
// -----------------------------------------------------------------------------
// alu_ccr_unit
// Execution stage behind the scratchpad register file. Single-cycle ops
// complete at the accept edge; SRL shifts serially one bit per cycle so the
// control unit can stall on Busy. Holds the {n,z,v,c} condition-code register.
// Ports:
//   uALU_CLOCK_50      in   clock, rising edge
//   uALU_RESET_InHigh  in   synchronous reset, active high
//   uALU_Start_In      in   request; accepted only in IDLE or DONE
//   uALU_Selection_In  in   opcode, sampled on accept
//   uALU_DataBUSA_In   in   operand A
//   uALU_DataBUSB_In   in   operand B (B[4:0] is the SRL shift amount)
//   uALU_Result_Out    out  registered result
//   uALU_Busy_Out      out  high while shifting
//   uALU_Done_Out      out  one-cycle pulse, result valid
//   uALU_CCR_Out       out  registered {n,z,v,c}
// -----------------------------------------------------------------------------
module alu_ccr_unit #(
  parameter int unsigned DATAWIDTH_BUS   = alu_pkg::DATAWIDTH_BUS,
  parameter int unsigned DATAWIDTH_SHAMT = alu_pkg::DATAWIDTH_SHAMT
) (
  input  logic                                        uALU_CLOCK_50,
  input  logic                                        uALU_RESET_InHigh,
  input  logic                                        uALU_Start_In,
  input  logic [alu_pkg::DATAWIDTH_ALU_SELECTION-1:0] uALU_Selection_In,
  input  logic [DATAWIDTH_BUS-1:0]                    uALU_DataBUSA_In,
  input  logic [DATAWIDTH_BUS-1:0]                    uALU_DataBUSB_In,
  output logic [DATAWIDTH_BUS-1:0]                    uALU_Result_Out,
  output logic                                        uALU_Busy_Out,
  output logic                                        uALU_Done_Out,
  output logic [alu_pkg::CCR_W-1:0]                   uALU_CCR_Out
);

  import alu_pkg::*;

  alu_state_t                 state_q;
  alu_state_t                 state_next;
  logic [DATAWIDTH_BUS-1:0]   result_q;
  logic [DATAWIDTH_BUS-1:0]   result_next;
  logic [DATAWIDTH_SHAMT-1:0] count_q;
  logic [DATAWIDTH_SHAMT-1:0] count_next;
  logic [CCR_W-1:0]           ccr_q;
  logic [CCR_W-1:0]           ccr_next;
  logic                       busy_q;
  logic                       done_q;

  logic [DATAWIDTH_BUS-1:0]   alu_result;
  logic                       alu_carry;
  logic                       alu_overflow;
  logic [CCR_W-1:0]           cc_flags;
  logic [DATAWIDTH_SHAMT-1:0] shamt;

  assign shamt = uALU_DataBUSB_In[DATAWIDTH_SHAMT-1:0];

  sc_alu_combinational #(
    .W (DATAWIDTH_BUS)
  ) u_alu (
    .sel      (uALU_Selection_In),
    .a        (uALU_DataBUSA_In),
    .b        (uALU_DataBUSB_In),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow)
  );

  // Flags for the flag-setting ops; v/c are only meaningful for ADDCC
  always_comb begin
    cc_flags        = '0;
    cc_flags[CCR_N] = alu_result[DATAWIDTH_BUS-1];
    cc_flags[CCR_Z] = (alu_result == '0);
    if (uALU_Selection_In == ALU_ADDCC) begin
      cc_flags[CCR_V] = alu_overflow;
      cc_flags[CCR_C] = alu_carry;
    end
  end

  // Next-state, datapath and flag update
  always_comb begin
    state_next  = state_q;
    result_next = result_q;
    count_next  = count_q;
    ccr_next    = ccr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (uALU_Start_In) begin
          if (uALU_Selection_In == ALU_SRL) begin
            result_next = uALU_DataBUSA_In;
            count_next  = shamt;
            state_next  = (shamt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            result_next = alu_result;
            state_next  = ST_DONE;
            if (is_cc_op(uALU_Selection_In)) begin
              ccr_next = cc_flags;
            end
          end
        end
      end
      ST_SHIFT: begin
        // Start is ignored here; nothing is queued
        result_next = result_q >> 1;
        count_next  = count_q - DATAWIDTH_SHAMT'(1);
        if (count_q == DATAWIDTH_SHAMT'(1)) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; Busy/Done decode the next state so they align
  // with the state they describe
  always_ff @(posedge uALU_CLOCK_50) begin
    if (uALU_RESET_InHigh) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      count_q  <= '0;
      ccr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_next;
      result_q <= result_next;
      count_q  <= count_next;
      ccr_q    <= ccr_next;
      busy_q   <= (state_next == ST_SHIFT);
      done_q   <= (state_next == ST_DONE);
    end
  end

  assign uALU_Result_Out = result_q;
  assign uALU_Busy_Out   = busy_q;
  assign uALU_Done_Out   = done_q;
  assign uALU_CCR_Out    = ccr_q;

endmodule
